// File: rtl/layered_objects_mux.sv
// layered_objects_mux: priority mux of colour-keyed object layers with blinking,
// 1-cycle registered RGB expansion and per-frame collision reporting.
module layered_objects_mux #(
  parameter int          NUM_LAYERS      = 4,
  parameter logic [7:0]  TRANSPARENT_RGB = 8'hFF,
  parameter int          BLINK_FRAMES    = 16
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [NUM_LAYERS-1:0]   drawingRequest,
  input  logic [8*NUM_LAYERS-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]   layerEnable,
  input  logic [NUM_LAYERS-1:0]   layerBlink,
  input  logic [7:0]              backGroundRGB,
  input  logic                    startOfFrame,
  output logic [7:0]              redOut,
  output logic [7:0]              greenOut,
  output logic [7:0]              blueOut,
  output logic [2:0]              winnerIndex,
  output logic                    pixelCollision,
  output logic [NUM_LAYERS-1:0]   collisionMask,
  output logic                    collisionValid
);
  logic [NUM_LAYERS-1:0] e, acc_d, acc_q, mask_q;
  logic [7:0] color_d, color_q, cnt_q;
  logic [2:0] win_d, win_q;
  logic multi, blink_q, coll_q, valid_q;
  always_comb begin
    e = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      e[i] = drawingRequest[i] & layerEnable[i] & (layerRGB[8*i+:8] != TRANSPARENT_RGB)
             & ~(layerBlink[i] & blink_q);
  end
  // Two or more bits set iff clearing the lowest set bit leaves something.
  assign multi = (e & (e - NUM_LAYERS'(1))) != '0;
  always_comb begin
    win_d   = 3'd7;
    color_d = backGroundRGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (e[i]) begin
        win_d   = 3'(i);
        color_d = layerRGB[8*i+:8];
      end
  end
  assign acc_d = startOfFrame ? (multi ? e : '0) : (multi ? (acc_q | e) : acc_q);
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      color_q <= '0;
      win_q   <= '0;
      coll_q  <= 1'b0;
      acc_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      color_q <= color_d;
      win_q   <= win_d;
      coll_q  <= multi;
      acc_q   <= acc_d;
      valid_q <= startOfFrame;
      if (startOfFrame) begin
        mask_q <= acc_q;
        if (cnt_q == 8'(BLINK_FRAMES - 1)) begin
          cnt_q   <= '0;
          blink_q <= ~blink_q;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end
  assign redOut         = {color_q[7:5], {5{color_q[5]}}};
  assign greenOut       = {color_q[4:2], {5{color_q[2]}}};
  assign blueOut        = {color_q[1:0], {6{color_q[0]}}};
  assign winnerIndex    = win_q;
  assign pixelCollision = coll_q;
  assign collisionMask  = mask_q;
  assign collisionValid = valid_q;
endmodule

// File: tb/tb_layered_objects_mux.sv
// tb_layered_objects_mux: scoreboard bench with a frame-index blink model plus directed checks.
module tb_layered_objects_mux;
  localparam int N = 4, BF = 2;
  logic clk = 0, resetN = 0;
  logic [N-1:0] dr = '0, en = '0, bl = '0;
  logic [8*N-1:0] rgb = '1;
  logic [7:0] bg = '0;
  logic sof = 0;
  logic [7:0] red, green, blue;
  logic [2:0] win;
  logic pc, valid;
  logic [N-1:0] mask;
  typedef struct packed {
    logic [7:0]   c;
    logic [2:0]   w;
    logic         p;
    logic [N-1:0] m;
    logic         v;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, frame_m = 0;
  logic [N-1:0] acc_m = '0, mask_m = '0;

  layered_objects_mux #(.NUM_LAYERS(N), .TRANSPARENT_RGB(8'hFF), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .resetN(resetN), .drawingRequest(dr), .layerRGB(rgb), .layerEnable(en),
    .layerBlink(bl), .backGroundRGB(bg), .startOfFrame(sof), .redOut(red), .greenOut(green),
    .blueOut(blue), .winnerIndex(win), .pixelCollision(pc), .collisionMask(mask),
    .collisionValid(valid));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_red"}, red, 0);
    chk({tag, "_green"}, green, 0);
    chk({tag, "_blue"}, blue, 0);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_mask"}, mask, 0);
    chk({tag, "_valid"}, valid, 0);
  endtask

  task automatic step();
    exp_t x;
    logic [N-1:0] e;
    logic boff;
    boff = ((frame_m / BF) % 2) == 1;
    for (int i = 0; i < N; i++)
      e[i] = dr[i] && en[i] && (rgb[8*i+:8] != 8'hFF) && !(bl[i] && boff);
    x.c = bg;
    x.w = 3'd7;
    for (int i = N - 1; i >= 0; i--)
      if (e[i]) begin
        x.c = rgb[8*i+:8];
        x.w = 3'(i);
      end
    x.p = $countones(e) > 1;
    if (sof) begin
      mask_m = acc_m;
      acc_m = x.p ? e : '0;
      frame_m++;
    end else if (x.p) acc_m = acc_m | e;
    x.m = mask_m;
    x.v = sof;
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("red", red, {x.c[7:5], {5{x.c[5]}}});
    chk("green", green, {x.c[4:2], {5{x.c[2]}}});
    chk("blue", blue, {x.c[1:0], {6{x.c[0]}}});
    chk("win", win, x.w);
    chk("pc", pc, x.p);
    chk("mask", mask, x.m);
    chk("valid", valid, x.v);
  endtask

  task automatic do_reset(input string tag);
    #2 resetN = 0;
    #1 chk_zero(tag);
    frame_m = 0;
    acc_m = '0;
    mask_m = '0;
    #1 resetN = 1;
  endtask

  initial begin
    #7 chk_zero("rst");
    #1 resetN = 1;
    // Two overlapping layers, lower index wins.
    en = 4'hF;
    dr = 4'b0101;
    rgb = {8'h00, 8'h1C, 8'h00, 8'hE0};
    step();
    chk("t34_red", red, 8'hFF);
    chk("t34_green", green, 8'h00);
    chk("t34_blue", blue, 8'h00);
    chk("t34_win", win, 0);
    chk("t34_pc", pc, 1);
    // Transparent layer falls through to the background.
    dr = 4'b0010;
    rgb = {8'h00, 8'h00, 8'hFF, 8'h00};
    bg = 8'h03;
    step();
    chk("t35_blue", blue, 8'hFF);
    chk("t35_red", red, 8'h00);
    chk("t35_green", green, 8'h00);
    chk("t35_win", win, 7);
    chk("t35_pc", pc, 0);
    dr = 4'b0011;
    rgb = {8'h00, 8'h00, 8'h40, 8'hFF};
    step();
    chk("tkey_pc", pc, 0);
    chk("tkey_win", win, 1);
    dr = '0;
    sof = 1;
    step();
    chk("t34_mask", mask, 4'b0101);
    sof = 0;
    dr = 4'b1010;
    rgb = {8'h11, 8'h00, 8'h22, 8'h00};
    step();
    dr = '0;
    step();
    step();
    sof = 1;
    step();
    chk("t36_mask", mask, 4'b1010);
    chk("t36_valid", valid, 1);
    sof = 0;
    dr = 4'b0100;
    step();
    chk("t36_valid_low", valid, 0);
    step();
    sof = 1;
    step();
    chk("t36_mask2", mask, 4'b0000);
    chk("t36_valid2", valid, 1);
    sof = 0;
    // Blinking layer 0 across frames 0..4.
    do_reset("t37_rst");
    dr = 4'b0001;
    rgb = {8'h00, 8'h00, 8'h00, 8'h1C};
    bl = 4'b0001;
    bg = 8'h00;
    step();
    chk("t37_win0", win, 0);
    for (int f = 1; f <= 4; f++) begin
      sof = 1;
      step();
      sof = 0;
      step();
      chk("t37_win", win, (f == 2 || f == 3) ? 7 : 0);
    end
    bl = '0;
    // Mid-frame reset discards the collision.
    dr = 4'b0101;
    rgb = {8'h00, 8'h1C, 8'h00, 8'hE0};
    step();
    do_reset("t38");
    dr = '0;
    step();
    sof = 1;
    step();
    chk("t38_mask", mask, 0);
    sof = 0;
    // Disabled layer never wins nor collides.
    dr = 4'b0110;
    en = 4'b1011;
    rgb = {8'h00, 8'h12, 8'h34, 8'h00};
    bg = 8'hE0;
    dr = 4'b0100;
    step();
    chk("t39_red", red, 8'hFF);
    chk("t39_win", win, 7);
    dr = 4'b0110;
    step();
    chk("t39_pc", pc, 0);
    sof = 1;
    step();
    chk("t39_mask", mask, 0);
    en = 4'hF;
    for (int n = 0; n < 300; n++) begin
      dr = 4'($urandom);
      en = 4'($urandom | $urandom);
      bl = 4'($urandom);
      bg = 8'($urandom);
      for (int i = 0; i < N; i++) rgb[8*i+:8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      sof = ($urandom_range(0, 7) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layered_objects_mux.md
LAYERED_OBJECTS_MUX -- requirements
Module: layered_objects_mux

Interface
REQ-001 Parameter NUM_LAYERS, default 4: number of object layers, legal range 1..8; layer 0 has highest priority.
REQ-002 Parameter TRANSPARENT_RGB, default 8'hFF: colour key; a layer pixel equal to this value is never drawn.
REQ-003 Parameter BLINK_FRAMES, default 16: frames per blink half-period, legal range 1..255.
REQ-004 clk  input  1  pixel clock; all state changes on rising edge.
REQ-005 resetN  input  1  reset; asynchronous, active-low.
REQ-006 drawingRequest  input  NUM_LAYERS  per-layer request; bit i belongs to layer i.
REQ-007 layerRGB  input  8*NUM_LAYERS  packed RRRGGGBB colours; layer i occupies bits [8i+7:8i].
REQ-008 layerEnable  input  NUM_LAYERS  per-layer static enable; 0 masks the layer.
REQ-009 layerBlink  input  NUM_LAYERS  per-layer blink mode; 1 hides the layer during the blink-off phase.
REQ-010 backGroundRGB  input  8  colour used when no layer wins.
REQ-011 startOfFrame  input  1  single-cycle pulse on the first pixel of each frame.
REQ-012 redOut, greenOut, blueOut  output  8 each  expanded 24-bit colour.
REQ-013 winnerIndex  output  3  index of the drawn layer; 3'd7 when background is drawn.
REQ-014 pixelCollision  output  1  high when two or more effective layers overlap on the output pixel.
REQ-015 collisionMask  output  NUM_LAYERS  layers involved in any collision during the previous complete frame.
REQ-016 collisionValid  output  1  single-cycle pulse when collisionMask is updated.

Function
REQ-017 Effective request e[i] SHALL be drawingRequest[i] AND layerEnable[i] AND (layerRGB slice i != TRANSPARENT_RGB) AND NOT (layerBlink[i] AND blinkOff).
REQ-018 The winner SHALL be the lowest index i with e[i]=1; with no e[i] set, the background colour is selected.
REQ-019 The selected 8-bit colour SHALL be registered once; outputs SHALL reflect inputs with exactly 1 clock latency.
REQ-020 Expansion SHALL be redOut={c[7:5], five copies of c[5]}, greenOut={c[4:2], five copies of c[2]}, blueOut={c[1:0], six copies of c[0]}.
REQ-021 winnerIndex and pixelCollision SHALL be registered in the same cycle as the colour, so they stay aligned with it.
REQ-022 pixelCollision SHALL be 1 when popcount(e) >= 2.
REQ-023 Frame accumulator: on every non-startOfFrame cycle with popcount(e) >= 2, accumulator SHALL become accumulator OR e.
REQ-024 On a startOfFrame cycle, collisionMask SHALL load the accumulator value held before that edge, and collisionValid SHALL be 1 for the following cycle only.
REQ-025 On the same startOfFrame cycle, the accumulator SHALL load e if popcount(e) >= 2, else 0; that pixel belongs to the new frame.
REQ-026 Frame counter: 8-bit; it SHALL increment on each startOfFrame.
REQ-027 When the frame counter reaches BLINK_FRAMES-1 on a startOfFrame, it SHALL wrap to 0 and blinkOff SHALL toggle.
REQ-028 A new blinkOff value SHALL take effect for e[] from the cycle after the startOfFrame edge.
REQ-029 With BLINK_FRAMES=1, blinkOff SHALL toggle on every startOfFrame.
REQ-030 Layers with NUM_LAYERS index and above do not exist; they have no request and no collision contribution.

Reset
REQ-031 While resetN=0, all outputs SHALL be 0 (winnerIndex=0, not 7), the accumulator 0, the frame counter 0 and blinkOff 0, irrespective of clk.
REQ-032 Reset assertion mid-frame SHALL discard accumulated collisions.
REQ-033 The first startOfFrame after reset SHALL report collisionMask=0 unless collisions occurred after reset.

Verification
REQ-034 Default parameters; layers 0 and 2 both request with 8'hE0 and 8'h1C, all enabled -> next cycle red=FF, green=00, blue=00, winnerIndex=0, pixelCollision=1.
REQ-035 Layer 1 requests with RGB=8'hFF, background=8'h03 -> blue=FF, red=00, green=00, winnerIndex=7, pixelCollision=0.
REQ-036 Overlap of layers 1 and 3 for one pixel, then startOfFrame -> collisionMask=4'b1010, collisionValid high exactly one cycle; next frame with no overlap reports 4'b0000.
REQ-037 BLINK_FRAMES=2; layer 0 blinking and requesting 8'h1C over background 8'h00 -> visible for frames 0-1, hidden (winnerIndex=7) for frames 2-3, visible again for frame 4.
REQ-038 Pulse resetN low mid-frame after a collision -> all outputs 0 immediately; next startOfFrame reports collisionMask=0.
REQ-039 Layer 2 requests with layerEnable[2]=0, background=8'hE0 -> red=FF, winnerIndex=7, no collision recorded.
